// File: rtl/riscv_pipe_fwd.sv
// Five-stage in-order RV64 subset core (ADD/SUB/ADDI/LD/SD/BEQ/ECALL) with
// optional MEM/WB operand bypass, load-use interlock and perf counters.
module riscv_pipe_fwd #(
  parameter int XLEN       = 64,
  parameter int FORWARD_EN = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [XLEN-1:0]  dmem_addr,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic [4:0]       dbg_rs,
  output logic [XLEN-1:0]  dbg_rdata,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam bit FWD = (FORWARD_EN != 0);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [2:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_ADDI, OP_LD, OP_SD, OP_BEQ, OP_ECALL
  } op_e;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } ifid_t;

  typedef struct packed {
    logic            valid;
    op_e             op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            wen;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } idex_t;

  typedef struct packed {
    logic            valid;
    op_e             op;
    logic [4:0]      rd;
    logic            wen;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sdata;
  } exmem_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            wen;
    logic            ecall;
    logic [XLEN-1:0] val;
  } memwb_t;

  logic [XLEN-1:0]  pc_q, pc_d;
  ifid_t            ifid_q, ifid_d;
  idex_t            idex_q, idex_d;
  exmem_t           exmem_q, exmem_d;
  memwb_t           memwb_q, memwb_d;
  logic             fetch_stop_q, fetch_stop_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0]  rf_q [32];

  // ---------------- ID: decode and write-first register read
  logic [6:0]      id_opc, id_f7;
  logic [2:0]      id_f3;
  logic [4:0]      id_rd, id_rs1, id_rs2;
  op_e             id_op;
  logic [XLEN-1:0] id_imm, imm_i, imm_s, imm_b, id_a, id_b;
  logic            id_use_rs1, id_use_rs2, id_wen, wb_we;

  assign id_opc = ifid_q.instr[6:0];
  assign id_rd  = ifid_q.instr[11:7];
  assign id_f3  = ifid_q.instr[14:12];
  assign id_rs1 = ifid_q.instr[19:15];
  assign id_rs2 = ifid_q.instr[24:20];
  assign id_f7  = ifid_q.instr[31:25];

  assign imm_i = {{(XLEN-12){ifid_q.instr[31]}}, ifid_q.instr[31:20]};
  assign imm_s = {{(XLEN-12){ifid_q.instr[31]}}, ifid_q.instr[31:25], ifid_q.instr[11:7]};
  assign imm_b = {{(XLEN-13){ifid_q.instr[31]}}, ifid_q.instr[31], ifid_q.instr[7],
                  ifid_q.instr[30:25], ifid_q.instr[11:8], 1'b0};

  always_comb begin
    id_op = OP_NOP;
    if (ifid_q.valid) begin
      if (ifid_q.instr == 32'h0000_0073) begin
        id_op = OP_ECALL;
      end else begin
        case (id_opc)
          7'b0110011: begin
            if (id_f3 == 3'b000 && id_f7 == 7'b0000000)      id_op = OP_ADD;
            else if (id_f3 == 3'b000 && id_f7 == 7'b0100000) id_op = OP_SUB;
          end
          7'b0010011: if (id_f3 == 3'b000) id_op = OP_ADDI;
          7'b0000011: if (id_f3 == 3'b011) id_op = OP_LD;
          7'b0100011: if (id_f3 == 3'b011) id_op = OP_SD;
          7'b1100011: if (id_f3 == 3'b000) id_op = OP_BEQ;
          default:    id_op = OP_NOP;
        endcase
      end
    end
  end

  always_comb begin
    case (id_op)
      OP_SD:   id_imm = imm_s;
      OP_BEQ:  id_imm = imm_b;
      default: id_imm = imm_i;
    endcase
  end

  assign id_use_rs1 = (id_op == OP_ADD) || (id_op == OP_SUB) || (id_op == OP_ADDI) ||
                      (id_op == OP_LD)  || (id_op == OP_SD)  || (id_op == OP_BEQ);
  assign id_use_rs2 = (id_op == OP_ADD) || (id_op == OP_SUB) || (id_op == OP_SD) ||
                      (id_op == OP_BEQ);
  assign id_wen     = ((id_op == OP_ADD) || (id_op == OP_SUB) || (id_op == OP_ADDI) ||
                       (id_op == OP_LD)) && (id_rd != 5'd0);

  // wen is never set for rd=x0, so x0 is never written nor used as a bypass source
  assign wb_we = memwb_q.valid && memwb_q.wen;
  assign id_a  = (id_rs1 == 5'd0) ? '0 :
                 (wb_we && memwb_q.rd == id_rs1) ? memwb_q.val : rf_q[id_rs1];
  assign id_b  = (id_rs2 == 5'd0) ? '0 :
                 (wb_we && memwb_q.rd == id_rs2) ? memwb_q.val : rf_q[id_rs2];

  // ---------------- EX: bypass, ALU, branch resolve
  logic            mem_fwd;
  logic [XLEN-1:0] ex_a, ex_b, ex_alu, br_target;
  logic            br_taken;

  // A load result only exists from WB onwards; the load-use stall covers the gap.
  assign mem_fwd = FWD && exmem_q.valid && exmem_q.wen && (exmem_q.op != OP_LD);

  always_comb begin
    ex_a = idex_q.a;
    ex_b = idex_q.b;
    if (mem_fwd && exmem_q.rd == idex_q.rs1)        ex_a = exmem_q.alu;
    else if (FWD && wb_we && memwb_q.rd == idex_q.rs1) ex_a = memwb_q.val;
    if (mem_fwd && exmem_q.rd == idex_q.rs2)        ex_b = exmem_q.alu;
    else if (FWD && wb_we && memwb_q.rd == idex_q.rs2) ex_b = memwb_q.val;
  end

  always_comb begin
    ex_alu = '0;
    case (idex_q.op)
      OP_ADD:                 ex_alu = ex_a + ex_b;
      OP_SUB:                 ex_alu = ex_a - ex_b;
      OP_ADDI, OP_LD, OP_SD:  ex_alu = ex_a + idex_q.imm;
      default:                ex_alu = '0;
    endcase
  end

  assign br_taken  = idex_q.valid && (idex_q.op == OP_BEQ) && (ex_a == ex_b);
  assign br_target = idex_q.pc + idex_q.imm;

  // ---------------- hazard detection
  logic hz_stall;

  always_comb begin
    hz_stall = 1'b0;
    if (FWD) begin
      if (idex_q.valid && idex_q.op == OP_LD && idex_q.wen &&
          ((id_use_rs1 && id_rs1 == idex_q.rd) || (id_use_rs2 && id_rs2 == idex_q.rd)))
        hz_stall = 1'b1;
    end else begin
      if (idex_q.valid && idex_q.wen &&
          ((id_use_rs1 && id_rs1 == idex_q.rd) || (id_use_rs2 && id_rs2 == idex_q.rd)))
        hz_stall = 1'b1;
      if (exmem_q.valid && exmem_q.wen &&
          ((id_use_rs1 && id_rs1 == exmem_q.rd) || (id_use_rs2 && id_rs2 == exmem_q.rd)))
        hz_stall = 1'b1;
    end
  end

  // ---------------- next-state
  always_comb begin
    pc_d         = pc_q;
    ifid_d       = ifid_q;
    fetch_stop_d = fetch_stop_q;

    idex_d.valid = ifid_q.valid;
    idex_d.op    = id_op;
    idex_d.rd    = id_rd;
    idex_d.rs1   = id_rs1;
    idex_d.rs2   = id_rs2;
    idex_d.wen   = id_wen;
    idex_d.a     = id_a;
    idex_d.b     = id_b;
    idex_d.imm   = id_imm;
    idex_d.pc    = ifid_q.pc;

    // A taken branch wins over any stall; ECALL stops fetch until reset.
    if (br_taken) begin
      pc_d         = br_target;
      ifid_d.valid = 1'b0;
      idex_d.valid = 1'b0;
    end else if (hz_stall) begin
      idex_d.valid = 1'b0;
    end else if (fetch_stop_q || id_op == OP_ECALL) begin
      ifid_d.valid = 1'b0;
      fetch_stop_d = 1'b1;
    end else begin
      pc_d         = pc_q + PC_STEP;
      ifid_d.valid = 1'b1;
      ifid_d.instr = imem_rdata;
      ifid_d.pc    = pc_q;
    end

    exmem_d.valid = idex_q.valid;
    exmem_d.op    = idex_q.op;
    exmem_d.rd    = idex_q.rd;
    exmem_d.wen   = idex_q.wen;
    exmem_d.alu   = ex_alu;
    exmem_d.sdata = ex_b;

    memwb_d.valid = exmem_q.valid;
    memwb_d.rd    = exmem_q.rd;
    memwb_d.wen   = exmem_q.wen;
    memwb_d.ecall = (exmem_q.op == OP_ECALL);
    memwb_d.val   = (exmem_q.op == OP_LD) ? dmem_rdata : exmem_q.alu;

    halted_d     = halted_q | (memwb_q.valid && memwb_q.ecall);
    retire_cnt_d = retire_cnt_q;
    if (memwb_q.valid && retire_cnt_q != '1) retire_cnt_d = retire_cnt_q + 1'b1;
    stall_cnt_d  = stall_cnt_q;
    if (hz_stall && !br_taken && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= '0;
      ifid_q       <= '0;
      idex_q       <= '0;
      exmem_q      <= '0;
      memwb_q      <= '0;
      fetch_stop_q <= 1'b0;
      halted_q     <= 1'b0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_q       <= ifid_d;
      idex_q       <= idex_d;
      exmem_q      <= exmem_d;
      memwb_q      <= memwb_d;
      fetch_stop_q <= fetch_stop_d;
      halted_q     <= halted_d;
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[memwb_q.rd] <= memwb_q.val;
    end
  end

  // ---------------- outputs
  assign imem_addr  = pc_q;
  assign dmem_addr  = exmem_q.alu;
  assign dmem_wdata = exmem_q.sdata;
  assign dmem_we    = exmem_q.valid && (exmem_q.op == OP_SD);
  assign dbg_rdata  = rf_q[dbg_rs];
  assign halted     = halted_q;
  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
